spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- SPI-peripheral configuration controller for the onboarding top level.
- Receives 16-bit write frames from an external SPI controller on uio/ui pins and decodes them.
- Drives the register bank that configures the PWM peripheral: output enables, PWM enables and duty cycle.
- Sits between the pad inputs and the PWM block. All SPI inputs are asynchronous to clk and are synchronised inside this block.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).
- MAX_ADDR, 7'h04, highest valid register address; writes above it are dropped.
- FRAME_BITS, 16, bits per valid frame.

Ports:
- clk  input  1  system clock (10 MHz nominal).
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock, asynchronous; must be at most clk/4.
- copi  input  1  SPI data in, asynchronous.
- ncs  input  1  SPI chip select, active-low, asynchronous.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- wr_strobe  output  1  one-cycle pulse when a register is updated.
- frame_err  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (asynchronous, rst=1):
  - All five registers = 8'h00; wr_strobe = 0; frame_err = 0.
  - Synchronisers flush to sclk=0, copi=0, ncs=1.
  - Bit counter = 0; FSM = IDLE.
- Synchronisation and edge detection:
  - sclk, copi and ncs each pass through SYNC_STAGES flops.
  - Edge detection compares the last sync stage with one extra history flop.
- Frame format: MSB first, sampled on sclk rising edge (SPI mode 0).
  - bit15 = R/W, 1 = write.
  - bits14:8 = address.
  - bits7:0 = data.
- FSM states:
  - IDLE: when synced ncs falls, clear shift register and counter, go to SHIFT.
  - SHIFT:
    - On each synced sclk rising edge with synced ncs low, shift in synced copi and increment the counter.
    - The counter saturates at 31.
    - When synced ncs rises, go to COMMIT.
  - COMMIT: exactly one cycle, then return to IDLE.
    - If counter == FRAME_BITS, bit15 = 1 and address <= MAX_ADDR: write data to the addressed register and pulse wr_strobe.
    - If counter != FRAME_BITS: pulse frame_err; no register changes.
    - If bit15 = 0 (read) or address > MAX_ADDR: silently dropped; no strobe, no err.
- Latency:
  - The register output and wr_strobe change on the clk edge ending COMMIT.
  - That edge is SYNC_STAGES+2 clk cycles after the raw ncs rising edge.
- Boundary conditions:
  - A sclk rise detected in the same cycle that synced ncs is already high is ignored.
  - More than 16 bits: rejected as frame_err, even if the first 16 bits are valid.
  - ncs glitch low with no sclk edges: counter = 0, so frame_err pulses.
  - sclk edges while ncs is high: ignored; the counter is unchanged.
  - Back-to-back frames: a new ncs fall arriving during COMMIT is seen in IDLE next cycle, because the synchronisers keep its history. No frame is lost.
  - rst asserted mid-frame: frame discarded, registers cleared. The next frame after release decodes normally.
- Register outputs are held stable between writes and are driven directly from flops.

Decomposition:
- Shared package spi_reg_pkg:
  - Address localparams ADDR_EN_OUT_LO=7'h00, ADDR_EN_OUT_HI=7'h01, ADDR_EN_PWM_LO=7'h02, ADDR_EN_PWM_HI=7'h03, ADDR_DUTY=7'h04.
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - Frame field bit positions.
- One sub-module, sync_edge: a parameterised SYNC_STAGES synchroniser with rise/fall detect outputs. It is instantiated for sclk and ncs; copi uses the synchroniser only.

Test Plan:
- Reset check: rst high for 5 cycles mid-traffic -> all 5 registers 8'h00, no wr_strobe or frame_err pulse.
- Write 0x80F0 (addr 0x00, data 0xF0) at sclk = clk/10 -> en_reg_out_7_0 = 8'hF0 and one wr_strobe pulse, 4 clk after ncs rises; other registers remain 0.
- Write 0x84 addr 0x04 data 0x80 -> pwm_duty_cycle = 8'h80. Then send read frame 0x0455 -> duty stays 8'h80, no strobe, no err.
- Write to addr 0x30 (frame 0xB0AA) -> no register change, no strobe, no err.
- Frame errors:
  - 15-bit frame 0x81xx truncated -> frame_err pulse, en_reg_out_15_8 unchanged.
  - 17-bit frame -> frame_err pulse, no write.
- Back-to-back frames 0x8201 then 0x8302 with ncs high for 3 clk between -> en_reg_pwm_7_0 = 01, en_reg_pwm_15_8 = 02, two wr_strobe pulses.
- Reset asserted after 8 bits of 0x84FF, then frame 0x8411 sent -> duty = 8'h11.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller.
// Holds the register address map, FSM state encoding and frame field positions.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Frame layout, MSB first on the wire: {rw, addr[6:0], data[7:0]}
    localparam int FRAME_RW       = 15;
    localparam int FRAME_ADDR_MSB = 14;
    localparam int FRAME_ADDR_LSB = 8;
    localparam int FRAME_DATA_MSB = 7;
    localparam int FRAME_DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous input, plus
// rise/fall detection against one history flop behind the last stage.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   din       - raw asynchronous input
//   q         - synchronised level
//   rise/fall - single-cycle edge pulses of the synchronised level
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            hist <= pipe[STAGES-1];
        end
    end

    assign q    = pipe[STAGES-1];
    assign rise = pipe[STAGES-1] & ~hist;
    assign fall = ~pipe[STAGES-1] & hist;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 write-only register controller for the PWM block.
// Receives 16-bit frames {rw, addr[6:0], data[7:0]} MSB first and updates one
// of five 8-bit configuration registers.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   sclk, copi, ncs   - raw asynchronous SPI pins
//   en_reg_*/pwm_duty_cycle - register outputs (flop driven)
//   wr_strobe         - one-cycle pulse on a register update
//   frame_err         - one-cycle pulse when the bit count is not FRAME_BITS
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04,
    parameter int         FRAME_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic sclk_s, sclk_rise;
    logic ncs_s, ncs_rise;
    logic [SYNC_STAGES-1:0] copi_pipe;
    logic copi_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .q(sclk_s), .rise(sclk_rise), .fall()
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(ncs), .q(ncs_s), .rise(ncs_rise), .fall()
    );

    // copi only needs its level; no edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) copi_pipe <= '0;
        else     copi_pipe <= {copi_pipe[SYNC_STAGES-2:0], copi};
    end
    assign copi_s = copi_pipe[SYNC_STAGES-1];

    state_t state, state_nxt;
    logic   clr, shift_en, commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            // Level test rather than the fall pulse: a fall that landed during
            // COMMIT is still visible as a low level here.
            IDLE: if (!ncs_s) begin
                clr       = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ncs_rise)       state_nxt = COMMIT;  // sclk rise in this cycle is dropped
                else if (sclk_rise) shift_en  = 1'b1;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [15:0] sr;
    logic [4:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr <= {sr[14:0], copi_s};
            if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
    end

    logic [6:0] addr;
    logic [7:0] data;
    logic       len_ok, do_wr;

    assign addr   = sr[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
    assign data   = sr[FRAME_DATA_MSB:FRAME_DATA_LSB];
    assign len_ok = (cnt == FRAME_CNT);
    assign do_wr  = commit && len_ok && sr[FRAME_RW] && (addr <= MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= do_wr;
            frame_err <= commit && !len_ok;
            if (do_wr) begin
                case (addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= data;
                    ADDR_DUTY:      pwm_duty_cycle  <= data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives SPI frames at sclk = clk/10 and
// checks register values, strobe/error pulses and commit latency.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    int errors = 0;
    int checks = 0;
    int n_stb  = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) n_stb++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        chk({tag, " out_lo"}, en_reg_out_7_0, r0);
        chk({tag, " out_hi"}, en_reg_out_15_8, r1);
        chk({tag, " pwm_lo"}, en_reg_pwm_7_0, r2);
        chk({tag, " pwm_hi"}, en_reg_pwm_15_8, r3);
        chk({tag, " duty"},   pwm_duty_cycle, r4);
    endtask

    // Shift out the low n bits of 'bits', MSB first; optionally raise ncs at the end.
    task automatic send_raw(input logic [31:0] bits, input int n, input bit raise);
        @(negedge clk);
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        if (raise) ncs = 1'b1;
    endtask

    // Call right after ncs rises (at a negedge): result lands on the 4th posedge.
    task automatic check_commit(input string tag, input logic exp_wr, input logic exp_err);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " strobe early"}, wr_strobe, 0);
        chk({tag, " err early"}, frame_err, 0);
        @(posedge clk);
        #1;
        chk({tag, " strobe"}, wr_strobe, exp_wr);
        chk({tag, " err"}, frame_err, exp_err);
        @(posedge clk);
        #1;
        chk({tag, " strobe width"}, wr_strobe, 0);
        chk({tag, " err width"}, frame_err, 0);
        repeat (4) @(negedge clk);
    endtask

    int stb0, err0;

    initial begin
        repeat (3) @(negedge clk);
        chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset strobe", wr_strobe, 0);
        chk("reset err", frame_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic write to 0x00
        send_raw(32'h80F0, 16, 1'b1);
        check_commit("wr00", 1'b1, 1'b0);
        chk_regs("wr00", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Duty write, then a read frame that must be dropped silently
        send_raw(32'h8480, 16, 1'b1);
        check_commit("wr04", 1'b1, 1'b0);
        chk("wr04 duty", pwm_duty_cycle, 8'h80);
        send_raw(32'h0455, 16, 1'b1);
        check_commit("rd04", 1'b0, 1'b0);
        chk("rd04 duty", pwm_duty_cycle, 8'h80);

        // Address above MAX_ADDR dropped
        send_raw(32'hB0AA, 16, 1'b1);
        check_commit("addr30", 1'b0, 1'b0);
        chk_regs("addr30", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);

        // 15-bit frame: top 15 bits of 0x81AB
        send_raw(32'h40D5, 15, 1'b1);
        check_commit("short", 1'b0, 1'b1);
        chk("short out_hi", en_reg_out_15_8, 8'h00);

        // 17-bit frame whose first 16 bits are a valid write 0x80AA
        send_raw(32'h10155, 17, 1'b1);
        check_commit("long", 1'b0, 1'b1);
        chk("long out_lo", en_reg_out_7_0, 8'hF0);

        // ncs glitch with no sclk edges
        @(negedge clk);
        ncs = 1'b0;
        @(negedge clk);
        ncs = 1'b1;
        check_commit("glitch", 1'b0, 1'b1);

        // sclk toggling with ncs high does nothing
        stb0 = n_stb;
        err0 = n_err;
        repeat (4) begin
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("idle sclk strobes", n_stb - stb0, 0);
        chk("idle sclk errs", n_err - err0, 0);

        // Back-to-back frames with ncs high for 3 clk between
        stb0 = n_stb;
        err0 = n_err;
        send_raw(32'h8201, 16, 1'b1);
        repeat (2) @(negedge clk);
        send_raw(32'h8302, 16, 1'b1);
        repeat (10) @(negedge clk);
        chk("b2b strobes", n_stb - stb0, 2);
        chk("b2b errs", n_err - err0, 0);
        chk_regs("b2b", 8'hF0, 8'h00, 8'h01, 8'h02, 8'h80);

        // Reset mid-frame after 8 bits of 0x84FF
        send_raw(32'h84, 8, 1'b0);
        stb0 = n_stb;
        err0 = n_err;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst strobes", n_stb - stb0, 0);
        chk("midrst errs", n_err - err0, 0);
        chk_regs("postrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_raw(32'h8411, 16, 1'b1);
        check_commit("wr11", 1'b1, 1'b0);
        chk_regs("wr11", 8'h00, 8'h00, 8'h00, 8'h00, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
